// File: rtl/seq_slice_adder_if.sv
// Operand/result handshake bundle for the sequential slice adder.
// The producer/consumer side uses master; the controller uses slave.
interface seq_slice_adder_if #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
);
    localparam int OPW = WIDTH * WORDS;

    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           cin;
    logic           out_valid;
    logic           out_ready;
    logic [OPW-1:0] sum;
    logic           cout;
    logic           busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/seq_slice_adder_ctrl.sv
// Wide unsigned a+b+cin computed one WIDTH-bit slice per cycle on a single adder slice.
//   state  | meaning
//   IDLE   | waiting for operands, in_ready high
//   RUN    | adding slice idx, carry passed to slice idx+1
//   DONE   | result held, out_valid high until out_ready
module seq_slice_adder_ctrl #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input logic            clk,
    input logic            rst,
    seq_slice_adder_if.slave bus
);
    localparam int OPW  = WIDTH * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [OPW-1:0]    a_q, b_q, sum_q;
    logic              load, step, last;

    logic [WIDTH-1:0]  a_w, b_w, slice_sum;
    logic              slice_co;

    assign a_w  = a_q[idx_q*WIDTH +: WIDTH];
    assign b_w  = b_q[idx_q*WIDTH +: WIDTH];
    assign last = (idx_q == IDXW'(WORDS - 1));

    always_comb begin
        {slice_co, slice_sum} = {1'b0, a_w} + {1'b0, b_w} + {{WIDTH{1'b0}}, carry_q};
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                step    = 1'b1;
                carry_d = slice_co;
                if (last) begin
                    cout_d  = slice_co;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            if (load) begin
                a_q <= bus.a;
                b_q <= bus.b;
            end
            if (step) begin
                sum_q[idx_q*WIDTH +: WIDTH] <= slice_sum;
            end
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_seq_slice_adder_ctrl.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and a randomized run against a plain a+b+cin reference with backpressure.
module tb_seq_slice_adder_ctrl;
    localparam int WIDTH = 4;
    localparam int WORDS = 4;
    localparam int OPW   = WIDTH * WORDS;
    localparam int NRAND = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    seq_slice_adder_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

    seq_slice_adder_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic           cin;
        logic [OPW-1:0] exp_sum;
        logic           exp_cout;
        int             hold;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge right after the accept edge; returns edges until out_valid.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_op(input string name, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                         input logic cin, input logic [OPW-1:0] es, input logic ec, input int hold);
        int lat;
        logic stable;
        chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({name, "_busy"}, 32'(bus.busy), 32'd1);
        wait_valid(lat);
        chk({name, "_latency"}, 32'(lat), 32'(WORDS));
        chk({name, "_sum"}, 32'(bus.sum), 32'(es));
        chk({name, "_cout"}, 32'(bus.cout), 32'(ec));
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (!bus.out_valid || bus.in_ready || bus.sum !== es || bus.cout !== ec) stable = 1'b0;
            end
            chk({name, "_hold_stable"}, 32'(stable), 32'd1);
        end
        release_out();
    endtask

    initial begin
        int   lat;
        logic saw_valid;

        vecs[0] = '{16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 10};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0};
        vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0};
        vecs[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 0};
        vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_sum", 32'(bus.sum), 32'd0);
        chk("reset_cout", 32'(bus.cout), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].hold);
        end

        // in_valid activity outside IDLE must be ignored.
        bus.in_valid = 1'b1;
        bus.a = 16'h0001;
        bus.b = 16'h0001;
        bus.cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = 16'hFFFF;
            bus.b = 16'hFFFF;
            bus.cin = 1'b1;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("ign_latency", 32'(lat), 32'(WORDS));
        chk("ign_sum", 32'(bus.sum), 32'h0002);
        chk("ign_cout", 32'(bus.cout), 32'd0);
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("ign_done_in_ready", 32'(bus.in_ready), 32'd0);
        chk("ign_done_sum", 32'(bus.sum), 32'h0002);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("ign_idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ign_next_busy", 32'(bus.busy), 32'd1);
        wait_valid(lat);
        chk("ign_next_latency", 32'(lat), 32'(WORDS));
        chk("ign_next_sum", 32'(bus.sum), 32'hFFFF);
        chk("ign_next_cout", 32'(bus.cout), 32'd1);
        release_out();

        // Reset during the second RUN cycle aborts the operation.
        bus.in_valid = 1'b1;
        bus.a = 16'h1234;
        bus.b = 16'h0FED;
        bus.cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        saw_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid || bus.busy) saw_valid = 1'b1;
        end
        chk("abort_no_output", 32'(saw_valid), 32'd0);
        do_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0);

        // Randomized traffic against a+b+cin with consumer backpressure.
        begin
            logic [OPW:0] exp_q[$];
            int           acc_q[$];
            logic [OPW:0] e;
            int           t, n_acc, n_res, guard;
            bit           got, drop;
            n_acc = 0;
            n_res = 0;
            guard = 0;
            got   = 1'b0;
            drop  = 1'b0;
            while (n_res < NRAND && guard < 40000) begin
                @(negedge clk);
                guard++;
                if (bus.out_valid && !got) begin
                    got = 1'b1;
                    chk("rand_result_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        t = acc_q.pop_front();
                        chk("rand_sum", 32'(bus.sum), 32'(e[OPW-1:0]));
                        chk("rand_cout", 32'(bus.cout), 32'(e[OPW]));
                        chk("rand_latency", 32'(cyc - t), 32'(WORDS));
                        n_res++;
                    end
                end
                bus.out_ready = ($urandom_range(0, 2) != 0);
                if (bus.out_valid && bus.out_ready) got = 1'b0;
                if (drop) begin
                    bus.in_valid = 1'b0;
                    drop = 1'b0;
                end
                if (!bus.in_valid && n_acc < NRAND && $urandom_range(0, 1) == 1) begin
                    bus.a = OPW'($urandom);
                    bus.b = OPW'($urandom);
                    bus.cin = 1'($urandom);
                    bus.in_valid = 1'b1;
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {{OPW{1'b0}}, bus.cin});
                    acc_q.push_back(cyc + 1);
                    n_acc++;
                    drop = 1'b1;
                end
            end
            bus.in_valid = 1'b0;
            chk("rand_results_count", 32'(n_res), 32'(NRAND));
            chk("rand_accepts_count", 32'(n_acc), 32'(NRAND));
            chk("rand_leftover", 32'(exp_q.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
